// File: rtl/billiard_pkg.sv
// Shared types for the collision event path: event record, type codes, ball-ID helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package billiard_pkg;

  // Highest ball index; ball vectors are [NUM_BALLS:0], ball 0 is the white ball.
  localparam int NUM_BALLS = 3;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_BALL = 2'd1,
    EVT_WALL = 2'd2,
    EVT_HOLE = 2'd3
  } coll_evt_type_t;

  // Ball IDs are carried at ball-vector width so they line up with the hit unit's ports.
  typedef struct packed {
    coll_evt_type_t     evt_type;
    logic [NUM_BALLS:0] ball_a;
    logic [NUM_BALLS:0] ball_b;
    logic [1:0]         wall;
  } coll_evt_t;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic logic [NUM_BALLS:0] onehot_to_id(input logic [NUM_BALLS:0] vec);
    logic [NUM_BALLS:0] id;
    id = '0;
    for (int i = NUM_BALLS; i >= 0; i--) begin
      if (vec[i]) id = i[NUM_BALLS:0];
    end
    return id;
  endfunction

endpackage

// File: rtl/collision_event_scheduler_if.sv
// Event replay port: one collision event per valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: producer holds the event while evt_valid && !evt_ready.
interface collision_event_scheduler_if;
  import billiard_pkg::*;

  logic               evt_valid;
  logic               evt_ready;
  coll_evt_type_t     evt_type;
  logic [NUM_BALLS:0] evt_ball_a;
  logic [NUM_BALLS:0] evt_ball_b;
  logic [1:0]         evt_wall;

  modport master (
    output evt_valid, evt_type, evt_ball_a, evt_ball_b, evt_wall,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_type, evt_ball_a, evt_ball_b, evt_wall,
    output evt_ready
  );

endinterface

// File: rtl/coll_evt_fifo.sv
// Synchronous FIFO of collision events with occupancy count; head is visible combinationally.
// Latency: a pushed entry is at the head one cycle after the push edge when the FIFO was empty.
// Backpressure: push is ignored when full unless a pop happens on the same edge; pop ignored when empty.
module coll_evt_fifo
  import billiard_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     push,
  input  coll_evt_t                push_dat,
  input  logic                     pop,
  output coll_evt_t                head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  coll_evt_t          mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        cnt_q;
  logic               push_acc;
  logic               pop_acc;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);

  // Entry storage: written at the tail, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/collision_event_scheduler.sv
// Captures per-frame collision pulses into staging slots and a FIFO, replays them after the next startOfFrame.
// Latency: capture edge -> FIFO one edge later; SOF edge -> evt_valid the following cycle, 1 event/cycle max.
// Backpressure: head held stable while !evt_ready; COLL_SCHED_TIMEOUT_EN adds a ready-wait timeout that drops the head.
module collision_event_scheduler
  import billiard_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic [NUM_BALLS:0]             balls_collide,
  input  logic [1:0][NUM_BALLS:0]        Balls_col_ID,
  input  logic [NUM_BALLS:0]             ballwall_collide,
  input  logic [1:0]                     collided_wall,
  input  logic [NUM_BALLS:0]             ballhole_collide,
  collision_event_scheduler_if.master    evt,
  output logic                           busy,
  output logic                           overflow,
  output logic [7:0]                     drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   remaining_q, remaining_d;

  coll_evt_t       hole_q, ball_q, wall_q;
  logic            hole_vld_q, ball_vld_q, wall_vld_q;
  coll_evt_t       hole_new, ball_new, wall_new;
  logic            hole_hit, ball_hit, wall_hit;
  logic            push_hole, push_ball, push_wall, push_ok;
  logic            drop_hole, drop_ball, drop_wall;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  coll_evt_t       fifo_push_dat, fifo_head;
  logic [CW-1:0]   fifo_count;

  logic            evt_vld;
  logic            tmo_fire;
  logic [2:0]      drop_n;
  logic [8:0]      drop_sum;

  coll_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .resetN   (resetN),
    .push     (fifo_push),
    .push_dat (fifo_push_dat),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign hole_hit = |ballhole_collide;
  assign ball_hit = |balls_collide;
  assign wall_hit = |ballwall_collide;

  assign hole_new = '{evt_type: EVT_HOLE, ball_a: onehot_to_id(ballhole_collide), ball_b: '0, wall: 2'd0};
  assign ball_new = '{evt_type: EVT_BALL, ball_a: Balls_col_ID[0], ball_b: Balls_col_ID[1], wall: 2'd0};
  assign wall_new = '{evt_type: EVT_WALL, ball_a: onehot_to_id(ballwall_collide), ball_b: '0, wall: collided_wall};

  // Push arbiter: one slot per edge, HOLE > BALL > WALL; a full FIFO keeps the slot loaded.
  always_comb begin
    push_ok       = !fifo_full || fifo_pop;
    push_hole     = hole_vld_q && push_ok;
    push_ball     = ball_vld_q && !hole_vld_q && push_ok;
    push_wall     = wall_vld_q && !hole_vld_q && !ball_vld_q && push_ok;
    fifo_push     = push_hole || push_ball || push_wall;
    fifo_push_dat = wall_q;
    if (push_hole)      fifo_push_dat = hole_q;
    else if (push_ball) fifo_push_dat = ball_q;
    // A slot is free for a new pulse if empty or draining on this same edge.
    drop_hole     = hole_hit && hole_vld_q && !push_hole;
    drop_ball     = ball_hit && ball_vld_q && !push_ball;
    drop_wall     = wall_hit && wall_vld_q && !push_wall;
  end

  // Staging slots: load on the pulse, clear when moved into the FIFO.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hole_vld_q <= 1'b0;
      ball_vld_q <= 1'b0;
      wall_vld_q <= 1'b0;
      hole_q     <= '0;
      ball_q     <= '0;
      wall_q     <= '0;
    end else begin
      if (hole_hit && !drop_hole) begin
        hole_vld_q <= 1'b1;
        hole_q     <= hole_new;
      end else if (push_hole) begin
        hole_vld_q <= 1'b0;
      end
      if (ball_hit && !drop_ball) begin
        ball_vld_q <= 1'b1;
        ball_q     <= ball_new;
      end else if (push_ball) begin
        ball_vld_q <= 1'b0;
      end
      if (wall_hit && !drop_wall) begin
        wall_vld_q <= 1'b1;
        wall_q     <= wall_new;
      end else if (push_wall) begin
        wall_vld_q <= 1'b0;
      end
    end
  end

`ifdef COLL_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;

  assign tmo_fire = (state_q == ST_PRESENT) && !evt.evt_ready &&
                    (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Ready-wait counter: runs only while the head is stalled, clears on any pop.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_PRESENT) && !evt.evt_ready && !tmo_fire) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo_fire       = 1'b0;
`endif

  // Dispatch FSM next state: a frame's worth of events is latched at SOF, later captures wait a frame.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    evt_vld     = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (startOfFrame && (fifo_count != '0)) begin
          state_d     = ST_PRESENT;
          remaining_d = fifo_count;
        end
      end
      ST_PRESENT: begin
        evt_vld = 1'b1;
        if ((evt.evt_ready || tmo_fire) && !fifo_empty) begin
          fifo_pop    = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CW'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Dispatch FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  assign drop_n   = {2'b0, drop_hole} + {2'b0, drop_ball} + {2'b0, drop_wall} + {2'b0, tmo_fire};
  assign drop_sum = {1'b0, drop_count} + {6'b0, drop_n};

  // Drop accounting: one overflow pulse per edge with any drop, saturating count.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      overflow   <= (drop_n != 3'd0);
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign busy           = (state_q == ST_PRESENT);
  assign evt.evt_valid  = evt_vld;
  assign evt.evt_type   = evt_vld ? fifo_head.evt_type : EVT_NONE;
  assign evt.evt_ball_a = evt_vld ? fifo_head.ball_a   : '0;
  assign evt.evt_ball_b = evt_vld ? fifo_head.ball_b   : '0;
  assign evt.evt_wall   = evt_vld ? fifo_head.wall     : 2'd0;

endmodule

// File: tb/tb_collision_event_scheduler.sv
// Directed bench for collision_event_scheduler with a queue scoreboard and a negedge monitor.
// Latency: n/a.
// Backpressure: evt_ready driven by the stimulus process.
module tb_collision_event_scheduler;
  import billiard_pkg::*;

`ifdef COLL_SCHED_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic                     clk = 1'b0;
  logic                     resetN;
  logic                     startOfFrame;
  logic [NUM_BALLS:0]       balls_collide;
  logic [1:0][NUM_BALLS:0]  Balls_col_ID;
  logic [NUM_BALLS:0]       ballwall_collide;
  logic [1:0]               collided_wall;
  logic [NUM_BALLS:0]       ballhole_collide;
  logic                     busy;
  logic                     overflow;
  logic [7:0]               drop_count;

  collision_event_scheduler_if evt_if ();

  collision_event_scheduler #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .balls_collide    (balls_collide),
    .Balls_col_ID     (Balls_col_ID),
    .ballwall_collide (ballwall_collide),
    .collided_wall    (collided_wall),
    .ballhole_collide (ballhole_collide),
    .evt              (evt_if),
    .busy             (busy),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  coll_evt_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic coll_evt_t mk(input coll_evt_type_t t, input int a, input int b, input int w);
    coll_evt_t e;
    e.evt_type = t;
    e.ball_a   = 4'(a);
    e.ball_b   = 4'(b);
    e.wall     = 2'(w);
    return e;
  endfunction

  function automatic int cur();
    return int'({evt_if.evt_type, evt_if.evt_ball_a, evt_if.evt_ball_b, evt_if.evt_wall});
  endfunction

  // Monitor: compare every accepted event against the scoreboard, and idle fields against zero.
  always @(negedge clk) begin
    if (resetN && evt_if.evt_valid && evt_if.evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt: got 0x%0h expected none", cur());
      end else begin
        coll_evt_t e;
        e = exp_q.pop_front();
        chk("evt_accept", cur(), int'(e));
      end
    end else if (!evt_if.evt_valid) begin
      chk("idle_fields_zero", cur(), 0);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] hole, input logic [3:0] bb, input logic [3:0] id0,
                       input logic [3:0] id1, input logic [3:0] wv, input logic [1:0] wc);
    ballhole_collide = hole;
    balls_collide    = bb;
    Balls_col_ID[0]  = id0;
    Balls_col_ID[1]  = id1;
    ballwall_collide = wv;
    collided_wall    = wc;
    step(1);
    ballhole_collide = '0;
    balls_collide    = '0;
    Balls_col_ID     = '0;
    ballwall_collide = '0;
    collided_wall    = '0;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    step(1);
    startOfFrame = 1'b0;
  endtask

  initial begin
    resetN           = 1'b0;
    startOfFrame     = 1'b0;
    balls_collide    = '0;
    Balls_col_ID     = '0;
    ballwall_collide = '0;
    collided_wall    = '0;
    ballhole_collide = '0;
    evt_if.evt_ready = 1'b0;

    // Reset state
    step(2);
    chk("rst_valid", int'(evt_if.evt_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    resetN = 1'b1;
    step(2);

    // Single wall hit
    pulse(4'b0000, 4'b0000, 4'd0, 4'd0, 4'b0100, 2'd2);
    exp_q.push_back(mk(EVT_WALL, 2, 0, 2));
    step(2);
    sof();
    chk("t1_valid", int'(evt_if.evt_valid), 1);
    chk("t1_head", cur(), int'(mk(EVT_WALL, 2, 0, 2)));
    chk("t1_busy", int'(busy), 1);
    evt_if.evt_ready = 1'b1;
    step(1);
    chk("t1_done", int'(evt_if.evt_valid), 0);
    chk("t1_busy_done", int'(busy), 0);
    evt_if.evt_ready = 1'b0;

    // Three simultaneous types: HOLE > BALL > WALL
    pulse(4'b1000, 4'b0011, 4'd0, 4'd1, 4'b0010, 2'd3);
    exp_q.push_back(mk(EVT_HOLE, 3, 0, 0));
    exp_q.push_back(mk(EVT_BALL, 0, 1, 0));
    exp_q.push_back(mk(EVT_WALL, 1, 0, 3));
    step(4);
    evt_if.evt_ready = 1'b1;
    sof();
    chk("t2_c0", int'(evt_if.evt_valid), 1);
    step(1);
    chk("t2_c1", int'(evt_if.evt_valid), 1);
    step(1);
    chk("t2_c2", int'(evt_if.evt_valid), 1);
    step(1);
    chk("t2_end", int'(evt_if.evt_valid), 0);
    evt_if.evt_ready = 1'b0;

    // Fill: 8 queued, 9th held in slot, 10th dropped
    for (int i = 0; i < 10; i++) begin
      pulse(4'b0000, 4'b0000, 4'd0, 4'd0, 4'(1 << (i % 4)), 2'(i % 4));
      if (i < 9) begin
        exp_q.push_back(mk(EVT_WALL, i % 4, 0, i % 4));
        chk("t3_no_overflow", int'(overflow), 0);
      end else begin
        chk("t3_overflow", int'(overflow), 1);
        chk("t3_drop_count", int'(drop_count), 1);
      end
      step(1);
      if (i == 9) chk("t3_overflow_pulse", int'(overflow), 0);
    end
    evt_if.evt_ready = 1'b1;
    sof();
    step(8);
    chk("t3_frame_end", int'(evt_if.evt_valid), 0);
    sof();
    chk("t3_ninth_valid", int'(evt_if.evt_valid), 1);
    step(1);
    chk("t3_ninth_done", int'(evt_if.evt_valid), 0);
    evt_if.evt_ready = 1'b0;

    // Back-pressure window with mid-window capture and ignored SOF
    pulse(4'b0000, 4'b0000, 4'd0, 4'd0, 4'b1000, 2'd1);
    exp_q.push_back(mk(EVT_WALL, 3, 0, 1));
    exp_q.push_back(mk(EVT_HOLE, 2, 0, 0));
    step(2);
    sof();
    for (int c = 0; c < 20; c++) begin
      chk("t4_hold", cur(), int'(mk(EVT_WALL, 3, 0, 1)));
      chk("t4_busy", int'(busy), 1);
      ballhole_collide = (c == 5) ? 4'b0100 : 4'b0000;
      startOfFrame     = (c == 10);
      step(1);
    end
    ballhole_collide = '0;
    startOfFrame     = 1'b0;
    evt_if.evt_ready = 1'b1;
    step(1);
    chk("t4_no_restart", int'(evt_if.evt_valid), 0);
    sof();
    chk("t4_late_valid", cur(), int'(mk(EVT_HOLE, 2, 0, 0)));
    step(1);
    chk("t4_late_done", int'(evt_if.evt_valid), 0);
    evt_if.evt_ready = 1'b0;

    // Ready stuck low
    pulse(4'b0000, 4'b0000, 4'd0, 4'd0, 4'b0001, 2'd0);
    step(2);
    sof();
`ifdef COLL_SCHED_TIMEOUT_EN
    step(3);
    chk("t5_before_tmo", int'(evt_if.evt_valid), 1);
    step(1);
    chk("t5_tmo_pop", int'(evt_if.evt_valid), 0);
    chk("t5_tmo_overflow", int'(overflow), 1);
    chk("t5_tmo_drop_count", int'(drop_count), 2);
`else
    step(6);
    chk("t5_wait", int'(evt_if.evt_valid), 1);
    exp_q.push_back(mk(EVT_WALL, 0, 0, 0));
    evt_if.evt_ready = 1'b1;
    step(1);
    chk("t5_done", int'(evt_if.evt_valid), 0);
    chk("t5_drop_count", int'(drop_count), 1);
    evt_if.evt_ready = 1'b0;
`endif

    // Reset during dispatch discards everything
    pulse(4'b0010, 4'b1100, 4'd2, 4'd3, 4'b0001, 2'd1);
    step(4);
    sof();
    chk("t6_present", int'(evt_if.evt_valid), 1);
    step(2);
    resetN = 1'b0;
    #1;
    chk("t6_rst_valid", int'(evt_if.evt_valid), 0);
    chk("t6_rst_fields", cur(), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_overflow", int'(overflow), 0);
    chk("t6_rst_drop_count", int'(drop_count), 0);
    step(1);
    resetN = 1'b1;
    step(2);
    sof();
    chk("t6_sof_empty", int'(evt_if.evt_valid), 0);
    step(2);
    chk("t6_still_idle", int'(evt_if.evt_valid), 0);
    chk("t6_busy_idle", int'(busy), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
